// File: rtl/boid_frame_scheduler_pkg.sv
// Shared constants and types for the boid display pipeline.
// Used by the frame scheduler, the pixel address calculator, and the
// wrapper, BPU and VGA controller that share the same display geometry.
package boid_frame_scheduler_pkg;

  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT) + 1;
  localparam int MAX_BOIDS           = 4;
  localparam int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS);
  localparam int X_WIDTH             = 10;
  localparam int Y_WIDTH             = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SWAP  = 3'd1,
    ST_SEL   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  // 8-bit counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/boid_frame_scheduler_if.sv
// Bundle between the frame scheduler and its surroundings.
//   master: VGA side / BPU mux side (drives screen_end, boid_x, boid_y)
//   slave : the scheduler (drives select, display RAM controls and status)
// Signals:
//   screen_end    end-of-visible-frame pulse
//   boid_x/boid_y position of the currently selected boid
//   boid_sel      BPU mux select
//   buf_swap      display RAM swap/clear pulse
//   disp_we       display RAM write enable (data is constant 1)
//   disp_addr     display RAM write address
//   busy          scheduler is walking a frame
//   frame_done    last boid of the frame has been handled
//   skip_count    off-screen boids skipped in the current frame
//   overrun_count screen_end pulses seen while busy
interface boid_frame_scheduler_if
  import boid_frame_scheduler_pkg::*;
();

  logic                           screen_end;
  logic [X_WIDTH-1:0]             boid_x;
  logic [Y_WIDTH-1:0]             boid_y;
  logic [BITS_FOR_BOIDS-1:0]      boid_sel;
  logic                           buf_swap;
  logic                           disp_we;
  logic [PIXEL_ADDRESS_WIDTH-1:0] disp_addr;
  logic                           busy;
  logic                           frame_done;
  logic [7:0]                     skip_count;
  logic [7:0]                     overrun_count;

  modport master (
    output screen_end, boid_x, boid_y,
    input  boid_sel, buf_swap, disp_we, disp_addr, busy, frame_done,
           skip_count, overrun_count
  );

  modport slave (
    input  screen_end, boid_x, boid_y,
    output boid_sel, buf_swap, disp_we, disp_addr, busy, frame_done,
           skip_count, overrun_count
  );

endinterface

// File: rtl/boid_frame_scheduler_pixel_addr_calc.sv
// Combinational pixel address: addr = x + VIDEO_WIDTH*y, with a bounds check.
// Ports:
//   x_i, y_i     pixel coordinates
//   addr_o       linear display RAM address (full width, no truncation)
//   on_screen_o  high when x < VIDEO_WIDTH and y < VIDEO_HEIGHT
module pixel_addr_calc
  import boid_frame_scheduler_pkg::*;
(
  input  logic [X_WIDTH-1:0]             x_i,
  input  logic [Y_WIDTH-1:0]             y_i,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] addr_o,
  output logic                           on_screen_o
);

  localparam logic [PIXEL_ADDRESS_WIDTH-1:0] ROW_STRIDE =
    PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);

  always_comb begin
    addr_o      = PIXEL_ADDRESS_WIDTH'(x_i) + ROW_STRIDE * PIXEL_ADDRESS_WIDTH'(y_i);
    on_screen_o = (x_i < X_WIDTH'(VIDEO_WIDTH)) && (y_i < Y_WIDTH'(VIDEO_HEIGHT));
  end

endmodule

// File: rtl/boid_frame_scheduler.sv
// Per-frame rebuild sequencer for the 1-bit boid display RAM.
// On screen_end it pulses buf_swap, then walks every BPU through the shared
// mux and writes one pixel per on-screen boid. Tracks skipped boids and
// screen_end pulses that arrive while a frame is still being built.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    slave side of boid_frame_scheduler_if
//
// state  | meaning
// IDLE   | waiting for screen_end
// SWAP   | buf_swap pulse, select boid 0, clear skip count
// SEL    | boid_sel stable, mux output settling
// WRITE  | pixel write (or skip) for the sampled boid
// DONE   | frame_done pulse; chain to SWAP if a frame is pending
module boid_frame_scheduler
  import boid_frame_scheduler_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  boid_frame_scheduler_if.slave  bus
);

  localparam logic [BITS_FOR_BOIDS-1:0] LAST_BOID = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  sched_state_e state_q, state_d;

  logic [BITS_FOR_BOIDS-1:0]      sel_q, sel_d;
  logic                           buf_swap_q, buf_swap_d;
  logic                           disp_we_q, disp_we_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                           busy_q, busy_d;
  logic                           frame_done_q, frame_done_d;
  logic [7:0]                     skip_q, skip_d;
  logic [7:0]                     overrun_q, overrun_d;
  logic                           pending_q, pending_d;

  logic [PIXEL_ADDRESS_WIDTH-1:0] calc_addr;
  logic                           calc_on_screen;
  logic                           last_boid;

  assign last_boid = (sel_q == LAST_BOID);

  pixel_addr_calc u_addr_calc (
    .x_i         (bus.boid_x),
    .y_i         (bus.boid_y),
    .addr_o      (calc_addr),
    .on_screen_o (calc_on_screen)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.screen_end) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_SEL;
      ST_SEL:   state_d = ST_WRITE;
      ST_WRITE: state_d = last_boid ? ST_DONE : ST_SEL;
      // A pulse landing in DONE itself is honoured here as well.
      ST_DONE:  state_d = (pending_q || bus.screen_end) ? ST_SWAP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Every output is registered, so values are derived from the state being
  // entered; the write decision is taken at the SEL->WRITE edge from the
  // settled mux output.
  always_comb begin
    sel_d        = sel_q;
    buf_swap_d   = (state_d == ST_SWAP);
    disp_we_d    = 1'b0;
    addr_d       = addr_q;
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    skip_d       = skip_q;
    overrun_d    = overrun_q;
    pending_d    = pending_q;

    if (bus.screen_end && (state_q != ST_IDLE)) begin
      overrun_d = sat_inc8(overrun_q);
      pending_d = 1'b1;
    end
    if (state_q == ST_DONE) pending_d = 1'b0;

    if (state_d == ST_SWAP) begin
      sel_d  = '0;
      skip_d = '0;
    end

    if (state_q == ST_SEL) begin
      disp_we_d = calc_on_screen;
      if (calc_on_screen) addr_d = calc_addr;
      else                skip_d = sat_inc8(skip_q);
    end

    if ((state_q == ST_WRITE) && !last_boid) sel_d = sel_q + BITS_FOR_BOIDS'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q        <= '0;
      buf_swap_q   <= 1'b0;
      disp_we_q    <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      skip_q       <= '0;
      overrun_q    <= '0;
      pending_q    <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      buf_swap_q   <= buf_swap_d;
      disp_we_q    <= disp_we_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      skip_q       <= skip_d;
      overrun_q    <= overrun_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.boid_sel      = sel_q;
  assign bus.buf_swap      = buf_swap_q;
  assign bus.disp_we       = disp_we_q;
  assign bus.disp_addr     = addr_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.skip_count    = skip_q;
  assign bus.overrun_count = overrun_q;

endmodule
